// File: rtl/fpu_execute.sv
// FPU execute/writeback: FP regfile, load/store, sign-injection, core dispatch.
// Define FPU_DEBUG_RD_EN to add a combinational regfile debug read port.

package fpu_pkg;
  typedef struct packed {
    logic        start;
    logic [6:0]  funct7;
    logic        load;
    logic        store;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] imm;
    logic [2:0]  frm;
  } decode_execute_t;
endpackage

module fpu_execute
  import fpu_pkg::*;
#(
  parameter int NREGS        = 32,
  parameter int CORE_TIMEOUT = 64
) (
  input  logic            CLK,
  input  logic            nRST,
  input  decode_execute_t idex,
  input  logic [31:0]     rs1_int_data,
  input  logic [2:0]      csr_frm,
  output logic            busy,
  output logic            done,
  output logic            exception,
  output logic [4:0]      fflags,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic            mem_ren,
  output logic            mem_wen,
  input  logic [31:0]     mem_rdata,
  input  logic            mem_busy,
  output logic            core_start,
  output logic [1:0]      core_op,
  output logic [2:0]      core_rm,
  output logic [31:0]     core_a,
  output logic [31:0]     core_b,
  input  logic            core_done,
  input  logic [31:0]     core_result,
  input  logic [4:0]      core_flags
`ifdef FPU_DEBUG_RD_EN
  ,
  input  logic [4:0]      dbg_sel,
  output logic [31:0]     dbg_data
`endif
);

  localparam int CW = $clog2(CORE_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(CORE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DEC, S_MEM, S_CORE,
    S_WB, S_DONE, S_EXC
  } state_t;

  state_t state, nxt, dec_nxt;

  logic [31:0]   f [NREGS];
  logic [6:0]    f7;
  logic          ld, st;
  logic [4:0]    rd;
  logic [11:0]   imm;
  logic [2:0]    frm;
  logic [31:0]   base, a, b, res;
  logic [CW-1:0] cnt;

  logic [31:0] ea;
  logic [2:0]  rm;
  logic [4:0]  f5;
  logic        sgn, mem_op, arith_ok;
  logic        is_core, is_sgnj;

  assign ea = base + {{20{imm[11]}}, imm};
  assign rm = (frm == 3'b111) ? csr_frm : frm;
  assign f5 = f7[6:2];

  assign mem_op   = ld | st;
  assign arith_ok = !mem_op && (f7[1:0] == 2'b00)
                    && (rm <= 3'b100);
  assign is_core  = arith_ok && (f5[4:2] == 3'b000);
  assign is_sgnj  = arith_ok && (f5 == 5'b00100)
                    && (rm <= 3'b010);

  always_comb begin
    sgn = a[31] ^ b[31];
    if (rm[1:0] == 2'b00) sgn = b[31];
    else if (rm[1:0] == 2'b01) sgn = ~b[31];
  end

  always_comb begin
    dec_nxt = S_EXC;
    unique case (1'b1)
      mem_op:  dec_nxt = (ea[1:0] != 2'b00)
                         ? S_EXC : S_MEM;
      is_core: dec_nxt = S_CORE;
      is_sgnj: dec_nxt = S_WB;
      default: dec_nxt = S_EXC;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (idex.start) nxt = S_DEC;
      S_DEC:  nxt = dec_nxt;
      S_MEM:  if (!mem_busy) nxt = ld ? S_WB : S_DONE;
      S_CORE: begin
        if (core_done) nxt = S_WB;
        else if (cnt == CNT_LAST) nxt = S_EXC;
      end
      S_WB:   nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= S_IDLE;
    else state <= nxt;
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE) || (state == S_EXC);
  assign exception = (state == S_EXC);
  assign mem_ren   = (state == S_MEM) && ld;
  assign mem_wen   = (state == S_MEM) && !ld;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREGS; i++) f[i] <= '0;
    end else if (state == S_WB) begin
      f[rd] <= res;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      f7         <= '0;
      ld         <= 1'b0;
      st         <= 1'b0;
      rd         <= '0;
      imm        <= '0;
      frm        <= '0;
      base       <= '0;
      a          <= '0;
      b          <= '0;
      res        <= '0;
      cnt        <= '0;
      fflags     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_start <= 1'b0;
      core_op    <= '0;
      core_rm    <= '0;
      core_a     <= '0;
      core_b     <= '0;
    end else begin
      core_start <= 1'b0;
      unique case (state)
        S_IDLE: if (idex.start) begin
          f7   <= idex.funct7;
          ld   <= idex.load;
          st   <= idex.store;
          rd   <= idex.rd;
          imm  <= idex.imm;
          frm  <= idex.frm;
          base <= rs1_int_data;
          a    <= f[idex.rs1];
          b    <= f[idex.rs2];
        end
        S_DEC: begin
          if (dec_nxt == S_MEM) begin
            mem_addr  <= ea;
            mem_wdata <= b;
          end
          if (dec_nxt == S_CORE) begin
            core_start <= 1'b1;
            core_op    <= f5[1:0];
            core_rm    <= rm;
            core_a     <= a;
            core_b     <= b;
            cnt        <= '0;
          end
          if (dec_nxt == S_WB) res <= {sgn, a[30:0]};
        end
        S_MEM: if (!mem_busy && ld) res <= mem_rdata;
        S_CORE: begin
          cnt <= cnt + 1'b1;
          // flags merge only on a real result, never on timeout
          if (core_done) begin
            res    <= core_result;
            fflags <= fflags | core_flags;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FPU_DEBUG_RD_EN
  assign dbg_data = f[dbg_sel];
`endif

endmodule

// File: tb/tb_fpu_execute.sv
// Scoreboard bench for fpu_execute: directed plan items plus random ops
// checked against an instruction-level reference model.

module tb_fpu_execute;
  import fpu_pkg::*;

  localparam int TMO = 64;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  decode_execute_t idex;
  logic [31:0]     rs1_int_data;
  logic [2:0]      csr_frm;
  logic            busy, done, exception;
  logic [4:0]      fflags;
  logic [31:0]     mem_addr, mem_wdata;
  logic            mem_ren, mem_wen;
  logic [31:0]     mem_rdata;
  logic            mem_busy;
  logic            core_start;
  logic [1:0]      core_op;
  logic [2:0]      core_rm;
  logic [31:0]     core_a, core_b;
  logic            core_done;
  logic [31:0]     core_result;
  logic [4:0]      core_flags;

  fpu_execute #(.NREGS(32), .CORE_TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST), .idex(idex),
    .rs1_int_data(rs1_int_data), .csr_frm(csr_frm),
    .busy(busy), .done(done), .exception(exception),
    .fflags(fflags), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .mem_rdata(mem_rdata),
    .mem_busy(mem_busy), .core_start(core_start),
    .core_op(core_op), .core_rm(core_rm),
    .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_result(core_result),
    .core_flags(core_flags)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit         exc;
    logic [4:0] ff;
    int         cyc;
  } done_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_t;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  rm;
    logic [31:0] a;
    logic [31:0] b;
  } core_t;

  done_t doneq[$];
  mem_t  memq[$];
  core_t coreq[$];

  logic [31:0] fr [32];
  logic [4:0]  ff;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: event occurred, none expected", nm);
  endtask

  always @(negedge CLK) begin : mon_done
    done_t e;
    if (done) begin
      if (doneq.size() == 0) flag("spurious_done");
      else begin
        e = doneq.pop_front();
        chk("exception", {31'b0, exception}, {31'b0, e.exc});
        chk("fflags", {27'b0, fflags}, {27'b0, e.ff});
        chk("done_cycle", cyc, e.cyc);
      end
    end else if (exception) flag("exception_without_done");
  end

  always @(negedge CLK) begin : mon_mem
    mem_t m;
    if (mem_ren || mem_wen) begin
      if (memq.size() == 0) flag("unexpected_mem_access");
      else begin
        m = memq[0];
        chk("mem_wen", {31'b0, mem_wen}, {31'b0, m.wr});
        chk("mem_ren", {31'b0, mem_ren}, {31'b0, !m.wr});
        chk("mem_addr", mem_addr, m.addr);
        if (m.wr) chk("mem_wdata", mem_wdata, m.data);
        if (!mem_busy) void'(memq.pop_front());
      end
    end
  end

  bit    cact = 0;
  bit    prev_cs = 0;
  core_t ce;
  always @(negedge CLK) begin : mon_core
    if (!nRST) cact = 0;
    else begin
      if (core_start) begin
        if (prev_cs) flag("core_start_width");
        else if (coreq.size() == 0) flag("unexpected_core_start");
        else begin
          ce = coreq.pop_front();
          cact = 1;
        end
      end
      if (cact) begin
        chk("core_op", {30'b0, core_op}, {30'b0, ce.op});
        chk("core_rm", {29'b0, core_rm}, {29'b0, ce.rm});
        chk("core_a", core_a, ce.a);
        chk("core_b", core_b, ce.b);
        if (core_done) cact = 0;
      end
    end
    prev_cs = core_start;
  end

  // Model computes the retire outcome, then the bench drives the op
  // and its memory/core responses until the unit is idle again.
  task automatic issue(
    input logic [6:0] f7, input logic ld, input logic st,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic [11:0] imm,
    input logic [2:0] frm, input logic [2:0] csr,
    input logic [31:0] base, input logic [31:0] rdata,
    input int mb, input int cd, input logic [31:0] cres,
    input logic [4:0] cfl, input bit intrude, input bit abort);
    int n, c, simm, f5;
    logic [31:0] ea;
    logic [2:0] rm;
    logic s;
    done_t e;
    bit quit;
    @(posedge CLK); #1;
    n = cyc;
    simm = (imm >= 12'd2048) ? int'(imm) - 4096 : int'(imm);
    ea = base + 32'(simm);
    rm = (frm == 3'd7) ? csr : frm;
    f5 = int'(f7[6:2]);
    e.exc = 1;
    e.cyc = n + 2;
    if (ld || st) begin
      if (ea % 4 == 0) begin
        e.exc = 0;
        if (ld) begin
          memq.push_back('{wr:1'b0, addr:ea, data:32'h0});
          fr[rd] = rdata;
          e.cyc = n + 4 + mb;
        end else begin
          memq.push_back('{wr:1'b1, addr:ea, data:fr[rs2]});
          e.cyc = n + 3 + mb;
        end
      end
    end else if (f7[1:0] == 2'b00 && rm < 3'd5) begin
      if (f5 < 4) begin
        coreq.push_back('{op:f7[3:2], rm:rm, a:fr[rs1], b:fr[rs2]});
        if (cd >= 0) begin
          e.exc = 0;
          fr[rd] = cres;
          ff = ff | cfl;
          e.cyc = n + 4 + cd;
        end else e.cyc = n + 2 + TMO;
      end else if (f5 == 4 && rm <= 3'd2) begin
        case (rm)
          3'd0: s = fr[rs2][31];
          3'd1: s = ~fr[rs2][31];
          default: s = fr[rs1][31] ^ fr[rs2][31];
        endcase
        e.exc = 0;
        fr[rd] = {s, fr[rs1][30:0]};
        e.cyc = n + 3;
      end
    end
    e.ff = ff;
    if (!abort) doneq.push_back(e);

    idex = '{start:1'b1, funct7:f7, load:ld, store:st,
             rs1:rs1, rs2:rs2, rd:rd, imm:imm, frm:frm};
    rs1_int_data = base;
    csr_frm = csr;
    mem_rdata = rdata;
    mem_busy = (mb > 0);
    @(posedge CLK); #1;
    idex.start = 1'b0;
    quit = 0;
    for (int t = 0; t < 400 && !quit; t++) begin
      c = cyc;
      idex.start = intrude && (c == n + 1 || c == n + 2);
      mem_busy = (mb > 0) && (c <= n + 1 + mb);
      core_done = (cd >= 0) && (c == n + 2 + cd);
      core_result = cres;
      core_flags = cfl;
      if (abort && c == n + 4) begin
        #2 nRST = 1'b0;
        #1 chk("abort_busy", {31'b0, busy}, 32'h0);
        for (int i = 0; i < 32; i++) fr[i] = 32'h0;
        ff = 5'h0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        core_done = 1'b1;
        core_flags = 5'h1F;
        core_result = 32'hDEADBEEF;
        @(posedge CLK); #1;
        core_done = 1'b0;
        quit = 1;
      end else begin
        @(posedge CLK); #1;
        if (!busy) quit = 1;
      end
    end
    if (!quit) flag("idle_timeout");
    idex.start = 1'b0;
    mem_busy = 1'b0;
    core_done = 1'b0;
  endtask

  localparam logic [6:0] ADD = 7'b0000000;
  localparam logic [6:0] SUB = 7'b0000100;
  localparam logic [6:0] MUL = 7'b0001000;
  localparam logic [6:0] SGN = 7'b0010000;

  initial begin
    logic [6:0] f7;
    logic [11:0] imm;
    logic [31:0] base;
    logic [2:0] frm;
    int kind;
    bit ld, st;
    idex = '0;
    rs1_int_data = '0;
    csr_frm = '0;
    mem_rdata = '0;
    mem_busy = 1'b0;
    core_done = 1'b0;
    core_result = '0;
    core_flags = '0;
    ff = '0;
    for (int i = 0; i < 32; i++) fr[i] = 32'h0;

    @(negedge CLK);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_exception", {31'b0, exception}, 32'h0);
    chk("rst_fflags", {27'b0, fflags}, 32'h0);
    chk("rst_mem_req", {30'b0, mem_ren, mem_wen}, 32'h0);
    chk("rst_core_start", {31'b0, core_start}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_core_oprm", {27'b0, core_op, core_rm}, 32'h0);
    chk("rst_core_a", core_a, 32'h0);
    chk("rst_core_b", core_b, 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // load / store / misaligned
    issue(ADD, 1, 0, 0, 0, 4, 12'd8, 0, 0, 32'h1000,
          32'h3F800000, 0, -1, 0, 0, 0, 0);
    issue(ADD, 0, 1, 0, 4, 0, 12'hFFC, 0, 0, 32'h1000,
          0, 0, -1, 0, 0, 0, 0);
    issue(ADD, 1, 0, 0, 0, 4, 12'd2, 0, 0, 32'h1000,
          32'h12345678, 0, -1, 0, 0, 0, 0);
    issue(ADD, 0, 1, 0, 4, 0, 12'd0, 0, 0, 32'h1000,
          0, 0, -1, 0, 0, 0, 0);
    // operands, second load with 3 stall cycles
    issue(ADD, 1, 0, 0, 0, 1, 12'd0, 0, 0, 32'h2000,
          32'h3F800000, 0, -1, 0, 0, 0, 0);
    issue(ADD, 1, 0, 0, 0, 2, 12'd4, 0, 0, 32'h2000,
          32'h40000000, 3, -1, 0, 0, 0, 0);
    // FADD with dynamic rm, then FMUL adding more flags
    issue(ADD, 0, 0, 1, 2, 5, 12'd0, 3'b111, 3'b001, 0,
          0, 0, 7, 32'h40400000, 5'b00001, 0, 0);
    issue(ADD, 0, 1, 0, 5, 0, 12'd16, 0, 0, 32'h3000,
          0, 2, -1, 0, 0, 0, 0);
    issue(MUL, 0, 0, 1, 2, 7, 12'd0, 3'b000, 3'b000, 0,
          0, 0, 2, 32'h40000000, 5'b10000, 0, 0);
    // sign injection, with a start pulse while busy
    issue(ADD, 1, 0, 0, 0, 3, 12'd0, 0, 0, 32'h4000,
          32'h40490FDB, 0, -1, 0, 0, 0, 0);
    issue(SGN, 0, 0, 3, 1, 6, 12'd0, 3'b001, 3'b000, 0,
          0, 0, -1, 0, 0, 1, 0);
    issue(ADD, 0, 1, 0, 6, 0, 12'd0, 0, 0, 32'h4000,
          0, 0, -1, 0, 0, 1, 0);
    // illegal encodings and core timeout
    issue(7'b0000001, 0, 0, 1, 2, 8, 0, 3'b000, 0, 0,
          0, 0, 1, 32'h1, 5'h1F, 0, 0);
    issue(ADD, 0, 0, 1, 2, 8, 0, 3'b101, 0, 0,
          0, 0, 1, 32'h1, 5'h1F, 0, 0);
    issue(7'b1111100, 0, 0, 1, 2, 8, 0, 3'b000, 0, 0,
          0, 0, 1, 32'h1, 5'h1F, 0, 0);
    issue(ADD, 0, 0, 1, 2, 8, 0, 3'b000, 0, 0,
          0, 0, -1, 0, 0, 0, 0);
    // reset while waiting on the core, then a stray core_done
    issue(SUB, 0, 0, 1, 2, 9, 0, 3'b010, 0, 0,
          0, 0, -1, 0, 0, 1, 1);
    issue(ADD, 0, 1, 0, 5, 0, 12'd0, 0, 0, 32'h5000,
          0, 0, -1, 0, 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 4);
      ld = (kind == 0);
      st = (kind == 1);
      base = $urandom;
      imm = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 7) != 0) begin
        base[1:0] = 2'b00;
        imm[1:0] = 2'b00;
      end
      frm = 3'($urandom_range(0, 7));
      if (kind == 2 || kind == 3)
        frm = ($urandom_range(0, 3) == 0) ? 3'd7
              : 3'($urandom_range(0, 2));
      case (kind)
        2: f7 = {3'b000, 2'($urandom), 2'b00};
        3: f7 = SGN;
        4: f7 = 7'($urandom);
        default: f7 = ADD;
      endcase
      issue(f7, ld, st, 5'($urandom), 5'($urandom),
            5'($urandom), imm, frm, 3'($urandom_range(0, 7)),
            base, $urandom, $urandom_range(0, 3),
            $urandom_range(0, 9), $urandom, 5'($urandom),
            $urandom_range(0, 3) == 0, 0);
    end

    repeat (5) @(posedge CLK);
    #1;
    chk("done_queue_drained", doneq.size(), 32'h0);
    chk("mem_queue_drained", memq.size(), 32'h0);
    chk("core_queue_drained", coreq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_execute.md
Name: fpu_execute

Overview:
- Execute/writeback end of the FPU custom extension; consumes the decode-to-execute bundle produced by the FPU decode stage.
- Owns the 32x32 single-precision FP register file and sequences three instruction classes:
  - loads and stores through a word memory port;
  - sign-injection ops, computed locally;
  - add/sub/mul/div, dispatched to an external multi-cycle FP arithmetic core over a start/done handshake.
- Accumulates IEEE exception flags (fflags) and reports illegal encodings to risc_mgmt.

Parameters:
- NREGS, 32, number of FP registers (address width = 5).
- CORE_TIMEOUT, 64, maximum cycles to wait for core_done before flagging an exception.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- idex  input  fpu_pkg::decode_execute_t  decode bundle: start, funct7, load, store, rs1, rs2, rd, imm[11:0], frm.
- rs1_int_data  input  32  integer rs1 value, used as the load/store base.
- csr_frm  input  3  dynamic rounding mode from the fcsr.
- busy  output  1  FPU occupied; pipeline must stall.
- done  output  1  one-cycle pulse when the instruction retires.
- exception  output  1  one-cycle pulse with done on illegal/misaligned/timeout.
- fflags  output  5  sticky NV,DZ,OF,UF,NX.
- mem_addr  output  32  word address.
- mem_wdata  output  32  store data.
- mem_ren  output  1  read request.
- mem_wen  output  1  write request.
- mem_rdata  input  32  load data.
- mem_busy  input  1  memory not ready.
- core_start  output  1  one-cycle start pulse to the arithmetic core.
- core_op  output  2  00 add, 01 sub, 10 mul, 11 div.
- core_rm  output  3  resolved rounding mode.
- core_a  output  32  operand A.
- core_b  output  32  operand B.
- core_done  input  1  core result valid.
- core_result  input  32  core result.
- core_flags  input  5  core exception flags.

Behaviour:
- Reset (asynchronous):
  - all FP registers = 0; fflags = 0; FSM = IDLE;
  - busy, done, exception, mem_ren, mem_wen, core_start = 0;
  - mem_addr, mem_wdata, core_op, core_rm, core_a, core_b = 0.
- IDLE:
  - idex.start=1 captures the bundle and register operands into internal registers; next state is DECODE.
  - idex.start is ignored outside IDLE.
- busy = 1 in every state except IDLE.
- DECODE (1 cycle), first matching rule wins:
  - Load: ea = rs1_int_data + sext(imm). ea[1:0]!=0 -> EXC, otherwise MEM.
  - Store: same address rule, wdata = F[rs2].
  - Arithmetic: fmt = funct7[1:0] must be 00, else EXC.
  - Rounding mode: rm = frm, or csr_frm when frm=111. Resolved rm 101, 110 or 111 -> EXC.
  - funct5 00000-00011 -> CORE.
  - funct5 00100 with rm 000/001/010 (SGNJ/SGNJN/SGNJX) -> WB, result formed as {sign op, F[rs1][30:0]}.
  - Any other funct5 -> EXC.
- MEM:
  - Drive mem_ren or mem_wen, mem_addr = ea, mem_wdata = F[rs2]; hold these while mem_busy=1.
  - First cycle with mem_busy=0: load latches mem_rdata and goes to WB; store goes to DONE.
- CORE:
  - core_start pulses for exactly 1 cycle on entry; core_op, core_rm, core_a, core_b stay stable until core_done.
  - On core_done: latch the result; fflags |= core_flags; go to WB.
  - Counter reaches CORE_TIMEOUT -> EXC with fflags unchanged.
- WB: F[rd] = result (1 cycle), then DONE.
- DONE: done=1 for 1 cycle, then IDLE. Earliest new start is the cycle after DONE.
- EXC: done=1 and exception=1 for 1 cycle, no register or memory write, then IDLE.
- No register x0 special case: F0 is writable.
- Minimum latency from start to done:
  - sign-injection: 4 cycles (IDLE, DECODE, WB, DONE);
  - load with no memory wait: 5 cycles;
  - store: 4 cycles.
- Reset mid-operation aborts immediately: any pending memory request and core result are dropped.
- fflags is sticky and clears only on reset.

Optional Feature:
- Macro: FPU_DEBUG_RD_EN.
- Defined:
  - adds input dbg_sel[4:0] and output dbg_data[31:0] = F[dbg_sel], combinational;
  - a write in WB to the same register is visible in the following cycle.
- Undefined: the ports do not exist and regfile behaviour is unchanged.

Test Plan:
- Load then store, with rs1_int_data=0x1000:
  - load, imm=8, mem_rdata=0x3F800000 -> mem_ren with mem_addr=0x1008; F[rd]=0x3F800000; done 5 cycles after start.
  - store of that register, imm=-4 -> mem_wen with mem_addr=0xFFC, mem_wdata=0x3F800000.
- Misaligned access: load with ea=0x1002 -> exception=1 with done, mem_ren never asserted, F unchanged.
- FADD with memory stalls, F1=0x3F800000, F2=0x40000000, frm=111, csr_frm=001:
  - core_start pulses once with core_op=00 and core_rm=001;
  - core_done after 7 cycles with result=0x40400000 and flags=00001 -> F[rd]=0x40400000, fflags=00001.
  - A later op with core_flags=10000 -> fflags=10001.
  - Also hold mem_busy=1 for 3 cycles during a load -> address held constant throughout, done delayed by exactly 3 cycles.
- Sign injection: FSGNJN with F3=0x40490FDB, rs2 positive -> result 0xC0490FDB.
- Illegal encodings:
  - fmt=01 -> exception;
  - frm=101 -> exception;
  - funct5=11111 -> exception;
  - core_done never arrives -> exception exactly CORE_TIMEOUT cycles after core_start.
- Reset and back-to-back issue:
  - nRST low while in CORE -> busy=0 and FSM=IDLE immediately;
  - a later core_done has no effect;
  - a start asserted while busy=1 is ignored.
